// File: rtl/nn_pkg.sv
// nn_pkg: shared word-width helpers, Flopoco exception codes and loader FSM encoding
package nn_pkg;
  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  function automatic int word_w(input int bit_width, input int extra_bits);
    return bit_width + extra_bits;
  endfunction
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/bank_addr_counter.sv
// bank_addr_counter: nested addr/bank counter with clear, increment and last-word flag
// Ports: clk, rst_n (async active-low), clr, inc -> addr, bank, last
module bank_addr_counter import nn_pkg::*; #(
  parameter int BANKS = 5,
  parameter int DEPTH = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          inc,
  output logic [clog2_min1(DEPTH)-1:0]  addr,
  output logic [clog2_min1(BANKS)-1:0]  bank,
  output logic                          last
);
  localparam int AW = clog2_min1(DEPTH);
  localparam int BW = clog2_min1(BANKS);
  logic addr_wrap;
  assign addr_wrap = addr == AW'(DEPTH - 1);
  assign last = addr_wrap && bank == BW'(BANKS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      bank <= '0;
    end else if (clr) begin
      addr <= '0;
      bank <= '0;
    end else if (inc) begin
      addr <= addr_wrap ? '0 : addr + 1'b1;
      bank <= addr_wrap ? bank + 1'b1 : bank;
    end
endmodule

// File: rtl/weight_loader.sv
// weight_loader: streams weight words neuron-major into layer-1/layer-2 banks via one-hot strobes
// Ports: clk, rst_n (async active-low), start, in_data/in_valid/in_ready handshake,
//        wr_en (one-hot bank strobe), wr_addr, wr_data, busy, done (pulse), err (sticky abort)
// Option: WEIGHT_LOADER_EXC_CHECK_EN aborts the load on an inf/NaN word when EXTRA_BITS=2
module weight_loader import nn_pkg::*; #(
  parameter int BIT_WIDTH      = 32,
  parameter int EXTRA_BITS     = 2,
  parameter int LAYER1_NEURONS = 3,
  parameter int LAYER2_NEURONS = 2,
  parameter int DEPTH          = 3
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic [word_w(BIT_WIDTH, EXTRA_BITS)-1:0]     in_data,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  output logic [LAYER1_NEURONS+LAYER2_NEURONS-1:0]     wr_en,
  output logic [clog2_min1(DEPTH)-1:0]                 wr_addr,
  output logic [word_w(BIT_WIDTH, EXTRA_BITS)-1:0]     wr_data,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         err
);
  localparam int W  = word_w(BIT_WIDTH, EXTRA_BITS);
  localparam int NB = LAYER1_NEURONS + LAYER2_NEURONS;
  localparam int AW = clog2_min1(DEPTH);
  localparam int BW = clog2_min1(NB);
  logic [1:0]    state, state_nxt;
  logic [AW-1:0] addr;
  logic [BW-1:0] bank;
  logic          last, accept, exc, wr, go;
  assign in_ready = state == ST_LOAD;
  assign busy     = state != ST_IDLE;
  assign accept   = in_ready && in_valid;
  assign go       = state == ST_IDLE && start;
`ifdef WEIGHT_LOADER_EXC_CHECK_EN
  // the top exception bit is set for both inf (10) and NaN (11)
  assign exc = EXTRA_BITS == 2 && (in_data[W-1 -: 2] == EXC_INF || in_data[W-1 -: 2] == EXC_NAN);
`else
  assign exc = 1'b0;
`endif
  assign wr = accept && !exc;
  always_comb
    state_nxt = state == ST_IDLE ? (start ? ST_LOAD : ST_IDLE) :
                state == ST_LOAD ? (!accept ? ST_LOAD : exc ? ST_IDLE : last ? ST_FLUSH : ST_LOAD) :
                ST_IDLE;
  bank_addr_counter #(.BANKS(NB), .DEPTH(DEPTH)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go),
    .inc   (wr),
    .addr  (addr),
    .bank  (bank),
    .last  (last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= ST_IDLE;
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_en <= wr ? NB'(1) << bank : '0;
      done  <= state == ST_FLUSH;
      if (wr) begin
        wr_addr <= addr;
        wr_data <= in_data;
      end
      if (go)
        err <= 1'b0;
      else if (accept && exc)
        err <= 1'b1;
    end
endmodule

// File: tb/tb_weight_loader.sv
// tb_weight_loader: directed self-checking bench for weight_loader
module tb_weight_loader;
  localparam int W  = 34;
  localparam int NB = 5;
  localparam int AW = 2;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NB-1:0] wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          busy, done, err;
  logic          s_start = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [1:0]    s_en;
  logic [0:0]    s_addr;
  logic [W-1:0]  s_wdata;
  logic          s_busy, s_done, s_err;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  weight_loader #(.BIT_WIDTH(32), .EXTRA_BITS(2), .LAYER1_NEURONS(3), .LAYER2_NEURONS(2), .DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );
  weight_loader #(.BIT_WIDTH(32), .EXTRA_BITS(2), .LAYER1_NEURONS(1), .LAYER2_NEURONS(1), .DEPTH(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_data(s_data), .in_valid(s_valid),
    .in_ready(s_ready), .wr_en(s_en), .wr_addr(s_addr), .wr_data(s_wdata),
    .busy(s_busy), .done(s_done), .err(s_err)
  );
  task automatic do_reset;
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; s_start = 1'b0; s_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
  endtask
  task automatic do_start;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic test_reset;
    do_reset();
    #1;
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b en=%b addr=%0d data=%h busy=%b done=%b err=%b, all must be 0",
               in_ready, wr_en, wr_addr, wr_data, busy, done, err);
    end
  endtask
  task automatic test_back_to_back;
    int idx = 0;
    do_reset();
    do_start();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_start: busy=%b rdy=%b, need 1 1", busy, in_ready);
    end
    in_valid = 1'b1; in_data = W'(1);
    while (idx < 15) begin
      @(posedge clk); #1;
      checks++;
      if (wr_en !== NB'(1) << (idx / 3) || wr_addr !== AW'(idx % 3) || wr_data !== W'(idx + 1) || done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_word%0d: en=%b addr=%0d data=%h done=%b, need en=%b addr=%0d data=%h done=0",
                 idx, wr_en, wr_addr, wr_data, done, NB'(1) << (idx / 3), idx % 3, idx + 1);
      end
      idx++;
      in_data = W'(idx + 1);
      if (idx == 15) in_valid = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_flush: busy=%b rdy=%b done=%b, need 1 0 0", busy, in_ready, done);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || wr_en !== '0) begin
      errors++;
      $display("FAIL b2b_done: done=%b busy=%b en=%b, need 1 0 00000", done, busy, wr_en);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_once: done=%b, need 0", done);
    end
  endtask
  task automatic test_stall;
    int idx = 0;
    int cyc = 0;
    logic was_valid;
    do_reset();
    do_start();
    in_valid = 1'b1; in_data = W'(1);
    while (idx < 15 && cyc < 60) begin
      was_valid = in_valid;
      @(posedge clk); #1;
      cyc++;
      checks++;
      if (was_valid) begin
        if (wr_en !== NB'(1) << (idx / 3) || wr_addr !== AW'(idx % 3) || wr_data !== W'(idx + 1)) begin
          errors++;
          $display("FAIL stall_word%0d: en=%b addr=%0d data=%h, need en=%b addr=%0d data=%h",
                   idx, wr_en, wr_addr, wr_data, NB'(1) << (idx / 3), idx % 3, idx + 1);
        end
        idx++;
        in_data = W'(idx + 1);
      end else if (wr_en !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_idle%0d: en=%b busy=%b, need 00000 1", idx, wr_en, busy);
      end
      in_valid = idx < 15 && !was_valid;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 15) begin
      errors++;
      $display("FAIL stall_timeout: %0d words written, need 15", idx);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: done=%b, need 1", done);
    end
  endtask
  task automatic test_start_in_load;
    int idx = 0;
    do_reset();
    do_start();
    in_valid = 1'b1; in_data = W'(1);
    while (idx < 15) begin
      @(posedge clk); #1;
      checks++;
      if (wr_en !== NB'(1) << (idx / 3) || wr_addr !== AW'(idx % 3) || wr_data !== W'(idx + 1)) begin
        errors++;
        $display("FAIL startload_word%0d: en=%b addr=%0d data=%h, need en=%b addr=%0d data=%h",
                 idx, wr_en, wr_addr, wr_data, NB'(1) << (idx / 3), idx % 3, idx + 1);
      end
      idx++;
      in_data = W'(idx + 1);
      start = idx == 5;
      if (idx == 15) in_valid = 1'b0;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL startload_done: done=%b busy=%b, need 1 0", done, busy);
    end
  endtask
  task automatic test_async_reset;
    int idx = 0;
    do_reset();
    do_start();
    in_valid = 1'b1; in_data = W'(1);
    while (idx < 7) begin
      @(posedge clk); #1;
      idx++;
      in_data = W'(idx + 1);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: rdy=%b en=%b addr=%0d data=%h busy=%b done=%b err=%b, all must be 0",
               in_ready, wr_en, wr_addr, wr_data, busy, done, err);
    end
    #2;
    rst_n = 1'b1;
    do_start();
    in_valid = 1'b1; in_data = W'(34'h0_0000_00AB);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (wr_en !== NB'(1) || wr_addr !== '0 || wr_data !== W'(34'h0_0000_00AB)) begin
      errors++;
      $display("FAIL midreset_reload: en=%b addr=%0d data=%h, need 00001 0 00000000ab", wr_en, wr_addr, wr_data);
    end
  endtask
  task automatic test_exception;
    int idx = 0;
    do_reset();
    do_start();
    in_valid = 1'b1; in_data = W'(1);
    while (idx < 4) begin
      @(posedge clk); #1;
      checks++;
      if (wr_en !== NB'(1) << (idx / 3) || wr_addr !== AW'(idx % 3) || wr_data !== W'(idx + 1)) begin
        errors++;
        $display("FAIL exc_word%0d: en=%b addr=%0d data=%h, need en=%b addr=%0d data=%h",
                 idx, wr_en, wr_addr, wr_data, NB'(1) << (idx / 3), idx % 3, idx + 1);
      end
      idx++;
      in_data = idx == 4 ? W'(34'h3_0000_0000) : W'(idx + 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef WEIGHT_LOADER_EXC_CHECK_EN
    checks++;
    if (wr_en !== '0 || err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL exc_abort: en=%b err=%b busy=%b rdy=%b, need 00000 1 0 0", wr_en, err, busy, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL exc_nodone: done=%b err=%b, need 0 1", done, err);
    end
    do_start();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL exc_clear: err=%b busy=%b, need 0 1", err, busy);
    end
`else
    checks++;
    if (wr_en !== 5'b00010 || wr_addr !== AW'(1) || wr_data !== W'(34'h3_0000_0000) || err !== 1'b0) begin
      errors++;
      $display("FAIL exc_unchecked: en=%b addr=%0d data=%h err=%b, need 00010 1 300000000 0",
               wr_en, wr_addr, wr_data, err);
    end
`endif
  endtask
  task automatic test_depth1;
    do_reset();
    @(posedge clk); #1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    s_valid = 1'b1; s_data = W'(34'h0_1234_5678);
    @(posedge clk); #1;
    s_data = W'(34'h1_9ABC_DEF0);
    checks++;
    if (s_en !== 2'b01 || s_addr !== 1'b0 || s_wdata !== W'(34'h0_1234_5678)) begin
      errors++;
      $display("FAIL d1_word0: en=%b addr=%0d data=%h, need 01 0 012345678", s_en, s_addr, s_wdata);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    checks++;
    if (s_en !== 2'b10 || s_addr !== 1'b0 || s_wdata !== W'(34'h1_9ABC_DEF0) || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL d1_word1: en=%b addr=%0d data=%h rdy=%b, need 10 0 19abcdef0 0", s_en, s_addr, s_wdata, s_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (s_done !== 1'b1 || s_busy !== 1'b0 || s_en !== 2'b00) begin
      errors++;
      $display("FAIL d1_done: done=%b busy=%b en=%b, need 1 0 00", s_done, s_busy, s_en);
    end
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_start_in_load();
    test_async_reset();
    test_exception();
    test_depth1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
